// File: rtl/wm_input_conditioner.sv
// Front-panel conditioner: synchronises, debounces and edge-detects the start, cycle and door inputs.
// Optional macro LONG_PRESS_EN: start_stop moves to release and long holds raise long_press instead.
module wm_input_conditioner #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int CNT_W             = 5,
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter int HOLD_W            = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start_raw,
  input  logic btn_cycle_raw,
  input  logic door_sw_raw,
  output logic start_stop,
  output logic cycle_select,
  output logic door_open,
  output logic long_press
);

  localparam int START = 0;
  localparam int CYCLE = 1;
  localparam int DOOR  = 2;
  // The door powers up as open so the controller never starts before it is proven closed.
  localparam logic [2:0]       RESET_LEVEL = 3'b100;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("wm_input_conditioner: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 2 || (DEBOUNCE_CYCLES - 1) >= (2 ** CNT_W)) begin : g_bad_cnt
    $error("wm_input_conditioner: CNT_W cannot hold DEBOUNCE_CYCLES-1");
  end
  if (LONG_PRESS_CYCLES < 1 || LONG_PRESS_CYCLES >= (2 ** HOLD_W)) begin : g_bad_hold
    $error("wm_input_conditioner: HOLD_W cannot hold LONG_PRESS_CYCLES");
  end

  logic [2:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [3];
  logic [CNT_W-1:0]       cnt_q  [3];
  logic [2:0]             s;
  logic [2:0]             d_q;
  logic [2:0]             flip;
  logic                   cycle_rise;
  logic                   start_evt;
  logic                   start_stop_q;
  logic                   cycle_select_q;

  assign raw = {door_sw_raw, btn_cycle_raw, btn_start_raw};

  // flip marks the edge on which a channel's debounced level changes.
  always_comb begin
    s    = '0;
    flip = '0;
    for (int i = 0; i < 3; i++) begin
      s[i]    = sync_q[i][SYNC_STAGES-1];
      flip[i] = (s[i] != d_q[i]) && (cnt_q[i] == CNT_LAST);
    end
  end

  assign cycle_rise = flip[CYCLE] & ~d_q[CYCLE];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= {SYNC_STAGES{RESET_LEVEL[i]}};
        cnt_q[i]  <= '0;
      end
      d_q <= RESET_LEVEL;
    end else begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        if ((s[i] == d_q[i]) || flip[i]) cnt_q[i] <= '0;
        else                             cnt_q[i] <= cnt_q[i] + 1'b1;
      end
      d_q <= d_q ^ flip;
    end
  end

`ifdef LONG_PRESS_EN
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

  logic [HOLD_W-1:0] hold_q;
  logic              start_fall;
  logic              long_press_q;

  assign start_fall = flip[START] & d_q[START];
  // A short press reports on release; a hold that reached the limit already reported as long_press.
  assign start_evt  = start_fall && (hold_q < HOLD_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q       <= '0;
      long_press_q <= 1'b0;
    end else begin
      if (!d_q[START] || start_fall) hold_q <= '0;
      else if (hold_q != HOLD_MAX)   hold_q <= hold_q + 1'b1;
      long_press_q <= d_q[START] && !start_fall && (hold_q == HOLD_MAX - 1'b1);
    end
  end

  assign long_press = long_press_q;
`else
  logic start_rise;

  assign start_rise = flip[START] & ~d_q[START];
  assign start_evt  = start_rise;
  assign long_press = 1'b0;
`endif

  // Start wins a same-cycle tie; the cycle-select pulse is dropped, not deferred.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_stop_q   <= 1'b0;
      cycle_select_q <= 1'b0;
    end else begin
      start_stop_q   <= start_evt;
      cycle_select_q <= cycle_rise & ~start_evt;
    end
  end

  assign start_stop   = start_stop_q;
  assign cycle_select = cycle_select_q;
  assign door_open    = d_q[DOOR];

endmodule

// File: tb/tb_wm_input_conditioner.sv
// Bench for wm_input_conditioner: directed front-panel scenarios plus randomized input runs,
// checked every cycle against a sliding-window reference model of the raw input history.
module tb_wm_input_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int LP   = 50;
`ifdef LONG_PRESS_EN
  localparam bit LP_ON = 1'b1;
`else
  localparam bit LP_ON = 1'b0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic sa    = 1'b0;
  logic sc    = 1'b0;
  logic sd    = 1'b0;
  logic start_stop, cycle_select, door_open, long_press;

  always #5 clk = ~clk;

  wm_input_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(5),
    .LONG_PRESS_CYCLES(LP), .HOLD_W(10)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_start_raw(sa), .btn_cycle_raw(sc), .door_sw_raw(sd),
    .start_stop(start_stop), .cycle_select(cycle_select),
    .door_open(door_open), .long_press(long_press)
  );

  int compared   = 0;
  int mismatched = 0;

  // reference model state: raw samples per edge, newest last, packed {door, cycle, start}
  logic [2:0] hist[$];
  logic [2:0] md = 3'b100;
  int n = 0;
  int rise_edge = 0;
  logic e_start = 1'b0, e_cycle = 1'b0, e_door = 1'b1, e_long = 1'b0;

  int n_start, n_cycle, n_long, last_start, last_cycle, door_fall, base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A level flips on edge n when the raw pin disagreed with it on all DEB
  // sampling edges n-SYNC-DEB+1 .. n-SYNC.
  task automatic model_edge();
    logic [2:0] prev, flip, rise, fall;
    int last;
    n++;
    if (reset) begin
      hist.delete();
      repeat (SYNC + DEB + 2) hist.push_back(3'b100);
      md = 3'b100;
      e_start = 1'b0; e_cycle = 1'b0; e_long = 1'b0; e_door = 1'b1;
      return;
    end
    hist.push_back({sd, sc, sa});
    if (hist.size() > 64) void'(hist.pop_front());
    last = hist.size() - 1;
    flip = '0;
    for (int ch = 0; ch < 3; ch++) begin
      flip[ch] = 1'b1;
      for (int k = SYNC; k < SYNC + DEB; k++)
        if (hist[last-k][ch] == md[ch]) flip[ch] = 1'b0;
    end
    prev = md;
    md   = md ^ flip;
    rise = flip & ~prev;
    fall = flip & prev;
    if (LP_ON) begin
      if (rise[0]) rise_edge = n;
      e_start = fall[0] && ((n - 1 - rise_edge) < LP);
      e_long  = prev[0] && md[0] && ((n - rise_edge) == LP);
    end else begin
      e_start = rise[0];
      e_long  = 1'b0;
    end
    e_cycle = rise[1] && !e_start;
    e_door  = md[2];
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("start_stop",   start_stop,   e_start);
    chk("cycle_select", cycle_select, e_cycle);
    chk("door_open",    door_open,    e_door);
    chk("long_press",   long_press,   e_long);
    if (start_stop === 1'b1)   begin n_start++; last_start = n; end
    if (cycle_select === 1'b1) begin n_cycle++; last_cycle = n; end
    if (long_press === 1'b1)   n_long++;
    if (door_open === 1'b0 && door_fall < 0) door_fall = n;
  endtask

  task automatic ticks(input int k);
    repeat (k) tick();
  endtask

  task automatic clr();
    n_start = 0; n_cycle = 0; n_long = 0;
    last_start = -1; last_cycle = -1; door_fall = -1;
  endtask

  initial begin
    clr();
    // reset with all raw inputs low
    reset = 1'b1;
    ticks(2);
    chk("reset_door_open", door_open, 1);
    chk("reset_start_stop", start_stop, 0);
    reset = 1'b0;

    // door proven closed after the full latency
    clr();
    base = n;
    ticks(25);
    chk("door_close_latency", door_fall - base, SYNC + DEB);
    chk("door_phase_pulses", n_start + n_cycle + n_long, 0);

    // long clean start press then release
    clr();
    sa = 1'b1;
    base = n;
    ticks(40);
    chk("press_start_count", n_start, LP_ON ? 0 : 1);
`ifndef LONG_PRESS_EN
    chk("press_start_latency", last_start - base, SYNC + DEB);
`endif
    sa = 1'b0;
    ticks(30);
    chk("release_start_count", n_start, 1);

    // bouncing cycle button, then a stable hold
    clr();
    sc = 1'b1;
    repeat (3) begin
      ticks(9);
      sc = 1'b0;
      tick();
      sc = 1'b1;
    end
    base = n;
    ticks(20);
    chk("bounce_cycle_count", n_cycle, 1);
    chk("bounce_cycle_latency", last_cycle - base, SYNC + DEB);
    sc = 1'b0;
    ticks(25);
    chk("bounce_release_count", n_cycle, 1);

    // both buttons rise together
    clr();
    sa = 1'b1; sc = 1'b1;
    ticks(30);
    sa = 1'b0; sc = 1'b0;
    ticks(25);
    chk("tie_start_count", n_start, 1);
    chk("tie_cycle_count", n_cycle, LP_ON ? 1 : 0);

    // reset mid-debounce restarts the count
    clr();
    sa = 1'b1;
    ticks(9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    base = n;
    ticks(25);
    chk("reset_mid_count", n_start, LP_ON ? 0 : 1);
`ifndef LONG_PRESS_EN
    chk("reset_redebounce_latency", last_start - base, SYNC + DEB);
`endif
    sa = 1'b0;
    ticks(25);
    chk("reset_release_count", n_start, 1);

    // short and long holds
    clr();
    sa = 1'b1;
    ticks(20);
    sa = 1'b0;
    ticks(25);
    chk("short_hold_start", n_start, 1);
    chk("short_hold_long", n_long, 0);
    clr();
    sa = 1'b1;
    ticks(100);
    sa = 1'b0;
    ticks(25);
    chk("long_hold_start", n_start, LP_ON ? 0 : 1);
    chk("long_hold_long", n_long, LP_ON ? 1 : 0);

    // randomized runs of input levels with occasional resets
    repeat (60) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      {sd, sc, sa} = 3'($urandom_range(0, 7));
      ticks($urandom_range(1, 25));
    end
    {sd, sc, sa} = 3'b000;
    ticks(25);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wm_input_conditioner.md
Name: wm_input_conditioner

Overview:
Front-panel input stage that sits directly upstream of the washing machine controller. It synchronises, debounces and edge-detects the raw start/stop button, cycle-select button and door switch. It produces the one-cycle start_stop and cycle_select pulses and the clean door_open level that the controller samples every clock.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per raw input (minimum 2)
DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised input must differ from its debounced level before that level flips (minimum 2)
CNT_W, 5, width of each debounce counter; must hold DEBOUNCE_CYCLES-1
LONG_PRESS_CYCLES, 1000, hold time in cycles that counts as a long press (used only with LONG_PRESS_EN)
HOLD_W, 10, width of the hold counter; must hold LONG_PRESS_CYCLES

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_start_raw  input  1  asynchronous start/stop button, 1 = pressed
btn_cycle_raw  input  1  asynchronous cycle-select button, 1 = pressed
door_sw_raw  input  1  asynchronous door switch, 1 = open
start_stop  output  1  one-cycle pulse per accepted start/stop press
cycle_select  output  1  one-cycle pulse per accepted cycle-select press
door_open  output  1  debounced door level, 1 = open
long_press  output  1  one-cycle pulse on a long start press (only with LONG_PRESS_EN, else tied 0)

Behaviour:
- Single clock domain. The only asynchronous inputs are the three raw pins.
- Reset is synchronous and active-high:
  - Start and cycle channels: synchroniser flops, debounced levels and counters reset to 0.
  - Door channel: synchroniser flops and debounced level reset to 1. The door is treated as open until it is proven closed.
  - Outputs after reset: start_stop=0, cycle_select=0, long_press=0, door_open=1.
- Reset asserted mid-debounce or mid-hold discards the count and emits no pulse.
- Per channel: a SYNC_STAGES-deep flop chain produces the synchronised bit s. A debounced level d and a counter cnt are kept.
  - If s == d: cnt <= 0.
  - If s != d and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - If s != d and cnt == DEBOUNCE_CYCLES-1: d <= s and cnt <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles clears cnt and never changes d.
- Latency: from the first clock edge that samples a stable raw change to the change of d is SYNC_STAGES+DEBOUNCE_CYCLES edges (18 at defaults).
- Edge pulses:
  - start_stop and cycle_select are registered outputs.
  - Each is high for exactly one cycle: the cycle in which its d first reads 1 after being 0.
  - Falling edges of d produce no pulse.
  - A held button gives one pulse only; there is no auto-repeat.
- Simultaneous accepted rising edges on start and cycle in the same cycle: start_stop wins and the cycle_select pulse is dropped.
- door_open = d of the door channel, registered, no edge detection. It is fully independent of the button channels.
- Counters never wrap: cnt is bounded by DEBOUNCE_CYCLES-1 and the hold counter saturates at LONG_PRESS_CYCLES.

Optional Feature:
LONG_PRESS_EN
- Defined:
  - A hold counter runs while the start channel's d=1 and saturates at LONG_PRESS_CYCLES.
  - When the count first reaches LONG_PRESS_CYCLES, long_press pulses for one cycle.
  - start_stop is emitted on release instead of press: one cycle, in the cycle where d falls, and only if the hold count < LONG_PRESS_CYCLES.
  - A long press therefore gives long_press only and never start_stop.
  - The hold counter clears on release and on reset.
  - The start-over-cycle priority rule applies to the release pulse.
- Undefined: start_stop fires on the press edge as described above, long_press is tied to 0, and no hold counter is built.

Test Plan:
1. Reset with all raw inputs 0 -> door_open=1 until door_sw_raw=0 is held 18 cycles, then door_open=0 on edge 18; start_stop, cycle_select and long_press stay 0 throughout.
2. btn_start_raw=1 held 40 cycles (defaults) -> exactly one start_stop pulse, on edge 18 after the press; release -> no pulse.
3. btn_cycle_raw bounces with 1-cycle low glitches every 10 cycles, then holds 1 for 20 cycles -> one cycle_select pulse, 18 edges after the last glitch.
4. Both buttons rise on the same edge and are held 30 cycles -> one start_stop pulse, zero cycle_select pulses.
5. btn_start_raw held 1 and reset asserted for 1 cycle at edge 10 -> no start_stop; the press is re-debounced from scratch and start_stop pulses 18 edges after reset deasserts.
6. With LONG_PRESS_EN and LONG_PRESS_CYCLES=50: a 20-cycle hold -> start_stop on release and no long_press; a 100-cycle hold -> long_press 50 cycles after d rises, and no start_stop on release.
